div_iter_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU instructions for the execute stage.
- Accepts operands from the issue/execute stage with a valid/ready handshake and iterates one quotient bit per cycle.
- Holds the result until writeback acknowledges it.
- Resolves the RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/div_iter_unit.sv | 115 +++++++++++
 tb/tb_div_iter_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk, rst_n, i_valid/o_ready request, i_op/i_rs1/i_rs2/i_rd, i_flush, o_valid/o_result/o_rd/i_ack.
module div_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  input  logic            i_ack
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            s1_q, s2_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;

  logic            accept, is_signed, div_zero, ovf;
  logic [XLEN-1:0] mag1, mag2, fix_res;
  logic [XLEN:0]   rem_sh, diff;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);

  assign accept    = i_valid & o_ready & ~i_flush;
  assign is_signed = ~i_op[0];
  assign mag1      = (is_signed && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
  assign mag2      = (is_signed && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
  assign div_zero  = (i_rs2 == '0);
  assign ovf       = is_signed && (i_rs1 == MIN_INT) && (i_rs2 == '1);

  // The shifted remainder can reach 2*divisor-1, so the extra top bit
  // both holds the carried-in bit and signals a negative trial result.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    fix_res = rem_q;
    unique case (op_q)
      2'b00: fix_res = (s1_q ^ s2_q) ? -quo_q : quo_q;
      2'b01: fix_res = quo_q;
      2'b10: fix_res = s1_q ? -rem_q : rem_q;
      2'b11: fix_res = rem_q;
      default: fix_res = rem_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (div_zero || ovf) ? DONE : CALC;
      CALC:  if (cnt_q == '0) state_d = FIXUP;
      FIXUP: state_d = DONE;
      DONE:  if (i_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      o_result <= '0;
      o_rd     <= '0;
    end else begin
      if (accept) begin
        op_q  <= i_op;
        o_rd  <= i_rd;
        s1_q  <= is_signed & i_rs1[XLEN-1];
        s2_q  <= is_signed & i_rs2[XLEN-1];
        rem_q <= '0;
        quo_q <= mag1;
        dvs_q <= mag2;
        cnt_q <= CW'(XLEN-1);
        if (div_zero)
          o_result <= i_op[1] ? i_rs1 : '1;
        else if (ovf)
          o_result <= i_op[1] ? '0 : i_rs1;
      end
      if (state_q == CALC) begin
        quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_q <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == FIXUP) o_result <= fix_res;
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed table, corner sequences, random vs model.
// Drives inputs on falling edges and samples outputs on falling edges.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        i_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush),
    .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
    .i_ack(i_ack)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : a;
    case (op)
      2'd0: return sa / sb;
      2'd1: return a / b;
      2'd2: return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // lat counts rising edges after the accept edge before o_valid is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat_exp,
                        input int hold);
    int n;
    int lat;
    logic busy_ok;
    logic stable;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_op = op;
    i_rs1 = a;
    i_rs2 = b;
    i_rd = rd;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!o_valid && lat < 100) begin
      if (o_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (o_ready) busy_ok = 1'b0;
    chk("latency", lat, lat_exp);
    chk("ready_low_busy", {31'b0, busy_ok}, 32'd1);
    chk("result", o_result, exp);
    chk("rd_tag", {27'b0, o_rd}, {27'b0, rd});
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!o_valid || o_result !== exp || o_rd !== rd) stable = 1'b0;
      end
      chk("hold_stable", {31'b0, stable}, 32'd1);
    end
    i_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ack = 1'b0;
    chk("idle_after_ack", {30'b0, o_valid, o_ready}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        seen;

    vecs.push_back('{2'd0, 32'd100,       32'hFFFF_FFF9, 5'd3,  32'hFFFF_FFF2, 33, 5});
    vecs.push_back('{2'd2, 32'd100,       32'hFFFF_FFF9, 5'd4,  32'h0000_0002, 33, 0});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'h0000_0010, 5'd17, 32'h0FFF_FFFF, 33, 0});
    vecs.push_back('{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 5'd17, 32'h0000_000F, 33, 0});
    vecs.push_back('{2'd0, 32'h1234_5678, 32'h0,         5'd5,  32'hFFFF_FFFF, 0,  2});
    vecs.push_back('{2'd2, 32'h1234_5678, 32'h0,         5'd6,  32'h1234_5678, 0,  0});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 0,  0});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 0,  0});
    vecs.push_back('{2'd0, 32'h0,         32'd5,         5'd9,  32'h0,         33, 0});
    vecs.push_back('{2'd1, 32'd7,         32'h0,         5'd10, 32'hFFFF_FFFF, 0,  0});
    vecs.push_back('{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 33, 0});
    vecs.push_back('{2'd0, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 33, 0});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 33, 0});

    #2;
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_ready", {31'b0, o_ready}, 32'd1);
    chk("reset_result", o_result, 32'd0);
    chk("reset_rd", {27'b0, o_rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat, vecs[i].hold);

    // flush at the tenth CALC cycle
    i_op = 2'd0;
    i_rs1 = 32'd1000;
    i_rs2 = 32'd3;
    i_rd = 5'd20;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (o_valid) seen = 1'b1;
      @(negedge clk);
    end
    i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_ready", {31'b0, o_ready}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_valid", {31'b0, seen}, 32'd0);
    run_op(2'd0, 32'd1000, 32'd3, 5'd21, 32'd333, 33, 0);

    // flush an unacknowledged result
    i_op = 2'd1;
    i_rs1 = 32'd9;
    i_rs2 = 32'd0;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("done_before_flush", {31'b0, o_valid}, 32'd1);
    i_flush = 1'b1;
    i_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_flush = 1'b0;
    i_ack = 1'b0;
    chk("flush_done", {30'b0, o_valid, o_ready}, 32'd1);

    // asynchronous reset mid-CALC
    i_op = 2'd1;
    i_rs1 = 32'hDEAD_BEEF;
    i_rs2 = 32'd77;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, o_ready}, 32'd1);
    chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {o_result[29:0], o_valid, o_ready}, 32'd1);
    chk("rst_release_result", o_result, 32'd0);

    for (int n = 0; n < 1500; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 15))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(1, 31);
        4: a = 32'h0;
        default: ;
      endcase
      run_op(op, a, b, rd, model(op, a, b), model_lat(op, a, b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
